// File: rtl/alarm_pkg.sv
// ---- alarm_pkg : controller state encoding and default keypad codes ----
// ---- rev 1.0 ----
`default_nettype none

package alarm_pkg;

   typedef enum logic [2:0] {
      S_DISARMED   = 3'd0,
      S_EXIT_DELAY = 3'd1,
      S_ARMED      = 3'd2,
      S_WAIT_DELAY = 3'd3,
      S_ALARM      = 3'd4,
      S_SILENCED   = 3'd5
   } state_t;

   localparam logic [3:0] ARM_CODE_DEF    = 4'b0011;
   localparam logic [3:0] DISARM_CODE_DEF = 4'b1100;

endpackage

`default_nettype wire

// File: rtl/alarm_zone_ctrl_if.sv
// ---- alarm_zone_ctrl_if : sensor/keypad inputs and siren/status outputs ----
// ---- rev 1.0 ----
`default_nettype none

interface alarm_zone_ctrl_if #(
   parameter int N_ZONES = 3
);
   logic               ENA;
   logic [N_ZONES-1:0] sensors;
   logic [N_ZONES-1:0] instant_mask;
   logic [3:0]         keypad;
   logic               alarm_siren;
   logic               is_armed;
   logic               is_exit_delay;
   logic               is_wait_delay;
   logic               is_silenced;
   logic [N_ZONES-1:0] trip_zones;

   modport master (
      output ENA, sensors, instant_mask, keypad,
      input  alarm_siren, is_armed, is_exit_delay, is_wait_delay, is_silenced, trip_zones
   );

   modport slave (
      input  ENA, sensors, instant_mask, keypad,
      output alarm_siren, is_armed, is_exit_delay, is_wait_delay, is_silenced, trip_zones
   );
endinterface

`default_nettype wire

// File: rtl/alarm_delay_cnt.sv
// ---- alarm_delay_cnt : loadable down-counter shared by exit/entry/siren delays ----
// ---- rev 1.0 ----
`default_nettype none

module alarm_delay_cnt #(
   parameter int CNT_W = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_ena,
   input  wire logic             i_load,
   input  wire logic [CNT_W-1:0] i_value,
   input  wire logic             i_dec,
   output logic      [CNT_W-1:0] o_cnt,
   output logic                  o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_ena) begin
         if (i_load) begin
            r_cnt <= i_value;
         end else if (i_dec && (r_cnt != '0)) begin
            // saturates at zero rather than wrapping
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/alarm_zone_ctrl.sv
// ---- alarm_zone_ctrl : N-zone intrusion alarm with exit/entry delays and bounded siren ----
// ---- rev 1.0 ----
`default_nettype none

module alarm_zone_ctrl
   import alarm_pkg::*;
#(
   parameter int         N_ZONES     = 3,
   parameter int         CNT_W       = 8,
   parameter int         EXIT_DELAY  = 50,
   parameter int         ENTRY_DELAY = 100,
   parameter int         SIREN_TIME  = 200,
   parameter logic [3:0] ARM_CODE    = ARM_CODE_DEF,
   parameter logic [3:0] DISARM_CODE = DISARM_CODE_DEF
) (
   input  wire logic         clk,
   input  wire logic         reset,
   alarm_zone_ctrl_if.slave  bus
);

   generate
      if ((N_ZONES < 1) || (N_ZONES > 16) ||
          (EXIT_DELAY  < 1) || (EXIT_DELAY  > (2**CNT_W)) ||
          (ENTRY_DELAY < 1) || (ENTRY_DELAY > (2**CNT_W)) ||
          (SIREN_TIME  < 1) || (SIREN_TIME  > (2**CNT_W))) begin : g_param_err
         $error("alarm_zone_ctrl: illegal parameter set");
      end
   endgenerate

   localparam logic [CNT_W-1:0] c_exit_ld  = CNT_W'(EXIT_DELAY  - 1);
   localparam logic [CNT_W-1:0] c_entry_ld = CNT_W'(ENTRY_DELAY - 1);
   localparam logic [CNT_W-1:0] c_siren_ld = CNT_W'(SIREN_TIME  - 1);

   state_t             r_state;
   state_t             w_nxt_state;
   logic               r_siren, r_armed, r_exit, r_wait, r_silenced;
   logic [N_ZONES-1:0] r_trip_zones;
   logic               w_inst, w_dly, w_trip, w_arm, w_disarm;
   logic               w_load, w_dec, w_zero;
   logic [CNT_W-1:0]   w_value, w_cnt;

   assign w_inst   = |(bus.sensors &  bus.instant_mask);
   assign w_dly    = |(bus.sensors & ~bus.instant_mask);
   assign w_trip   = w_inst | w_dly;
   assign w_arm    = (bus.keypad == ARM_CODE);
   assign w_disarm = (bus.keypad == DISARM_CODE);

   alarm_delay_cnt #(.CNT_W(CNT_W)) u_delay_cnt (
      .clk     (clk),
      .rst     (reset),
      .i_ena   (bus.ENA),
      .i_load  (w_load),
      .i_value (w_value),
      .i_dec   (w_dec),
      .o_cnt   (w_cnt),
      .o_zero  (w_zero)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_load      = 1'b0;
      w_value     = '0;
      w_dec       = 1'b0;
      case (r_state)
         S_DISARMED: begin
            if (w_arm) begin
               w_nxt_state = S_EXIT_DELAY;
               w_load      = 1'b1;
               w_value     = c_exit_ld;
            end
         end
         S_EXIT_DELAY: begin
            if (w_disarm)    w_nxt_state = S_DISARMED;
            else if (w_zero) w_nxt_state = S_ARMED;
            else             w_dec       = 1'b1;
         end
         S_ARMED: begin
            if (w_disarm) begin
               w_nxt_state = S_DISARMED;
            end else if (w_inst) begin
               w_nxt_state = S_ALARM;
               w_load      = 1'b1;
               w_value     = c_siren_ld;
            end else if (w_dly) begin
               w_nxt_state = S_WAIT_DELAY;
               w_load      = 1'b1;
               w_value     = c_entry_ld;
            end
         end
         S_WAIT_DELAY: begin
            if (w_disarm) begin
               w_nxt_state = S_DISARMED;
            end else if (w_inst || w_zero) begin
               w_nxt_state = S_ALARM;
               w_load      = 1'b1;
               w_value     = c_siren_ld;
            end else begin
               w_dec = 1'b1;
            end
         end
         S_ALARM: begin
            if (w_disarm)    w_nxt_state = S_DISARMED;
            else if (w_zero) w_nxt_state = S_SILENCED;
            else             w_dec       = 1'b1;
         end
         S_SILENCED: begin
            if (w_disarm) begin
               w_nxt_state = S_DISARMED;
            end else if (w_trip) begin
               w_nxt_state = S_ALARM;
               w_load      = 1'b1;
               w_value     = c_siren_ld;
            end
         end
         default: w_nxt_state = S_DISARMED;
      endcase
      // idle states hold the counter at zero; a disarm mid-delay clears any residue
      if ((w_nxt_state inside {S_DISARMED, S_ARMED, S_SILENCED}) && (w_cnt != '0)) begin
         w_load  = 1'b1;
         w_value = '0;
         w_dec   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_DISARMED;
         r_siren      <= 1'b0;
         r_armed      <= 1'b0;
         r_exit       <= 1'b0;
         r_wait       <= 1'b0;
         r_silenced   <= 1'b0;
         r_trip_zones <= '0;
      end else if (bus.ENA) begin
         r_state    <= w_nxt_state;
         r_siren    <= (r_state == S_ALARM);
         r_armed    <= (r_state == S_ARMED);
         r_exit     <= (r_state == S_EXIT_DELAY);
         r_wait     <= (r_state == S_WAIT_DELAY);
         r_silenced <= (r_state == S_SILENCED);
         if (w_nxt_state == S_DISARMED) begin
            r_trip_zones <= '0;
         end else if ((r_state == S_ARMED) && (w_nxt_state != S_ARMED)) begin
            r_trip_zones <= bus.sensors;
         end else if (r_state inside {S_WAIT_DELAY, S_ALARM, S_SILENCED}) begin
            r_trip_zones <= r_trip_zones | bus.sensors;
         end
      end
   end

   assign bus.alarm_siren   = r_siren;
   assign bus.is_armed      = r_armed;
   assign bus.is_exit_delay = r_exit;
   assign bus.is_wait_delay = r_wait;
   assign bus.is_silenced   = r_silenced;
   assign bus.trip_zones    = r_trip_zones;

endmodule

`default_nettype wire
